// File: rtl/tug_game_ctrl.sv
// tug_game_ctrl: round sequencer for the tug-of-war game.
// Owns the rope position and runs the reset/dark/play/victory round cycle.
// Drives the display select code plus the score and victory patterns.
// Optional feature macro: FALSE_START_PENALTY_EN (press during DARK is penalised).
module tug_game_ctrl #(
   parameter int RESET_TICKS = 500,
   parameter int DARK_MIN    = 500,
   parameter int WAIT_TICKS  = 250,
   parameter int BLINK_TICKS = 250
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       btn_l,
   input  logic       btn_r,
   output logic [2:0] led_control,
   output logic [6:0] score,
   output logic [6:0] victory_led
);

   // State encodings double as the display select code
   typedef enum logic [2:0] {
      DARK     = 3'b000,
      RST_SHOW = 3'b001,
`ifdef FALSE_START_PENALTY_EN
      PENALTY  = 3'b010,
`endif
      PLAY     = 3'b011,
      VICTORY  = 3'b111
   } state_t;

   localparam logic [15:0] RESET_LOAD = 16'(RESET_TICKS);
   localparam logic [15:0] BLINK_LOAD = 16'(BLINK_TICKS);
`ifdef FALSE_START_PENALTY_EN
   localparam logic [15:0] WAIT_LOAD  = 16'(WAIT_TICKS);
`endif

   state_t      state, state_n;
   logic [2:0]  pos, pos_n;
   logic [15:0] cnt, cnt_n;
   logic [7:0]  lfsr;
   logic        blink, blink_n;
   logic        press, last;
   logic [15:0] dark_load;
   logic [6:0]  score_n;

   assign press     = btn_l | btn_r;
   // Final tick of a phase: counter reads 1 (or 0 for a degenerate load)
   assign last      = tick && (cnt <= 16'd1);
   assign dark_load = 16'(DARK_MIN) + {12'd0, lfsr[3:0]};
   assign score_n   = 7'd1 << pos_n;

   // Next-state, position, phase counter and blink phase
   always_comb begin
      state_n = state;
      pos_n   = pos;
      blink_n = blink;
      cnt_n   = (tick && cnt != 16'd0) ? cnt - 16'd1 : cnt;
      case (state)
         RST_SHOW: begin
            if (last) begin
               state_n = DARK;
               cnt_n   = dark_load;
            end
         end
         DARK: begin
`ifdef FALSE_START_PENALTY_EN
            if (press) begin
               // False start pushes the rope toward the presser's opponent
               if (btn_l && !btn_r)
                  pos_n = (pos == 3'd0) ? 3'd0 : pos - 3'd1;
               else if (btn_r && !btn_l)
                  pos_n = (pos == 3'd6) ? 3'd6 : pos + 3'd1;
               if (pos_n == 3'd0 || pos_n == 3'd6) begin
                  state_n = VICTORY;
                  cnt_n   = BLINK_LOAD;
                  blink_n = 1'b1;
               end else begin
                  state_n = PENALTY;
                  cnt_n   = WAIT_LOAD;
               end
            end else
`endif
            if (last)
               state_n = PLAY;
         end
         PLAY: begin
            if (press) begin
               if (btn_l && !btn_r)
                  pos_n = (pos == 3'd6) ? 3'd6 : pos + 3'd1;
               else if (btn_r && !btn_l)
                  pos_n = (pos == 3'd0) ? 3'd0 : pos - 3'd1;
               if (pos_n == 3'd0 || pos_n == 3'd6) begin
                  state_n = VICTORY;
                  cnt_n   = BLINK_LOAD;
                  blink_n = 1'b1;
               end else begin
                  state_n = DARK;
                  cnt_n   = dark_load;
               end
            end
         end
`ifdef FALSE_START_PENALTY_EN
         PENALTY: begin
            if (last) begin
               state_n = DARK;
               cnt_n   = dark_load;
            end
         end
`endif
         VICTORY: begin
            if (last) begin
               blink_n = ~blink;
               cnt_n   = BLINK_LOAD;
            end
         end
         default: begin
            state_n = RST_SHOW;
            cnt_n   = RESET_LOAD;
         end
      endcase
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RST_SHOW;
         pos         <= 3'd3;
         cnt         <= RESET_LOAD;
         blink       <= 1'b0;
         lfsr        <= 8'hA5;
         led_control <= 3'b001;
         score       <= 7'b0001000;
         victory_led <= 7'd0;
      end else begin
         state       <= state_n;
         pos         <= pos_n;
         cnt         <= cnt_n;
         blink       <= blink_n;
         lfsr        <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
         led_control <= state_n;
         score       <= score_n;
         victory_led <= (state_n == VICTORY && blink_n) ? score_n : 7'd0;
      end
   end

endmodule
